// File: rtl/sisc_mem_resp.sv
// Memory-side responder for the SISC request/ready handshake: one word access
// at a time against an internal single-port array, after a fixed number of wait states.
module sisc_mem_resp #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              ready_reg;
  logic              err_reg;
  logic              busy_reg;
  logic              rd_valid_reg;
  logic [DATA_W-1:0] mem_rd_reg;

  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = ({1'b0, addr_reg} < DEPTH_LIM);
  assign idx      = addr_reg[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      ready_reg    <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            we_reg    <= we;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            busy_reg  <= 1'b1;
            cnt_reg   <= WAIT_INIT;
            state_reg <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ST_ACCESS;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_ACCESS: begin
          ready_reg <= 1'b1;
          state_reg <= ST_RESP;
          // Out-of-range access forces the visible read data to zero.
          if (!in_range) begin
            err_reg      <= 1'b1;
            rd_valid_reg <= 1'b0;
          end else if (!we_reg) begin
            rd_valid_reg <= 1'b1;
          end
        end
        ST_RESP: begin
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Array plus registered read port, kept free of reset so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state_reg == ST_ACCESS && in_range) begin
      if (we_reg) begin
        mem[idx] <= wdata_reg;
      end else begin
        mem_rd_reg <= mem[idx];
      end
    end
  end

  assign rdata = rd_valid_reg ? mem_rd_reg : '0;
  assign ready = ready_reg;
  assign err   = err_reg;
  assign busy  = busy_reg;

endmodule
